// File: rtl/i2c_target_ctrl.sv
// i2c_target_ctrl: I2C target that ACKs TGT_ADDR, delivers written bytes and requests read bytes.
//   clk      in   system clock, at least 16x SCL
//   rst      in   asynchronous active-high reset
//   scl_i    in   SCL pin level (asynchronous)
//   sda_i    in   SDA pin level (asynchronous)
//   sda_oe   out  1 = pull SDA low, 0 = release
//   rx_data  out  last byte written by the master
//   rx_valid out  1-cycle strobe, rx_data valid
//   tx_req   out  1-cycle strobe, next read byte needed on tx_data
//   tx_data  in   read byte, sampled on the SCL fall after tx_req
//   busy     out  1 from address ACK until STOP or repeated START
//   rd_mode  out  R/W bit of the current addressed transfer
module i2c_target_ctrl #(
    parameter logic [6:0] TGT_ADDR    = 7'b0001001,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       rd_mode
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK} state_t;
    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic [3:0]             cnt_q, cnt_d;
    logic [7:0]             shreg_q, shreg_d, rx_data_q, rx_data_d, byte_in;
    logic                   sda_oe_q, sda_oe_d, busy_q, busy_d, rd_mode_q, rd_mode_d;
    logic                   rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
    logic                   scl_s, sda_s, scl_rise, scl_fall, scl_hi, start_ev, stop_ev;
    // Synchronisers reset to the idle-bus level so leaving reset creates no SDA edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end
    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    // START/STOP only count when SCL was high in both samples; an SDA edge
    // coinciding with an SCL edge is a plain bit event.
    assign scl_hi   = scl_s & scl_prev_q;
    assign start_ev = scl_hi & ~sda_s & sda_prev_q;
    assign stop_ev  = scl_hi & sda_s & ~sda_prev_q;
    assign byte_in  = {shreg_q[6:0], sda_s};
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rd_mode_d  = rd_mode_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        if (stop_ev) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_ev) begin
            state_d  = ADDR;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                IDLE: sda_oe_d = 1'b0;
                ADDR: if (scl_rise) begin
                    shreg_d = byte_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        state_d   = (byte_in[7:1] == TGT_ADDR) ? ADDR_ACK : IDLE;
                        rd_mode_d = (byte_in[7:1] == TGT_ADDR) ? byte_in[0] : rd_mode_q;
                    end
                end
                // sda_oe_q tells the first fall (start driving ACK) from the second (end of ACK).
                ADDR_ACK: begin
                    tx_req_d = scl_rise & sda_oe_q & rd_mode_q;
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else if (rd_mode_q) begin
                            shreg_d  = tx_data;
                            sda_oe_d = ~tx_data[7];
                            state_d  = RD_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WR_DATA;
                        end
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shreg_d = byte_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        rx_data_d  = byte_in;
                        rx_valid_d = 1'b1;
                        state_d    = WR_ACK;
                    end
                end
                WR_ACK: if (scl_fall) begin
                    sda_oe_d = ~sda_oe_q;
                    state_d  = sda_oe_q ? WR_DATA : WR_ACK;
                end
                // shreg[7] is the bit on the wire; cnt counts rises seen for this byte.
                RD_DATA: begin
                    if (scl_rise && cnt_q != 4'd8) cnt_d = cnt_q + 4'd1;
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = RD_ACK;
                        end else begin
                            shreg_d  = {shreg_q[6:0], 1'b0};
                            sda_oe_d = ~shreg_q[6];
                        end
                    end
                end
                // cnt=1 marks that the master ACKed and another byte follows.
                RD_ACK: begin
                    if (scl_rise) begin
                        tx_req_d = ~sda_s;
                        cnt_d    = sda_s ? cnt_q : 4'd1;
                        state_d  = sda_s ? IDLE : RD_ACK;
                    end
                    if (scl_fall && cnt_q == 4'd1) begin
                        shreg_d  = tx_data;
                        sda_oe_d = ~tx_data[7];
                        state_d  = RD_DATA;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (state_d != state_q) cnt_d = '0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rd_mode_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rd_mode_q  <= rd_mode_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
        end
    end
    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign rd_mode  = rd_mode_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
endmodule

// File: tb/tb_i2c_target_ctrl.sv
// tb_i2c_target_ctrl: bus-master model driving i2c_target_ctrl, checked against transaction-level expectations.
module tb_i2c_target_ctrl;
    localparam int         Q   = 5;
    localparam logic [6:0] TGT = 7'h09;
    logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, rx_valid, tx_req, busy, rd_mode, sda_line;
    logic [7:0] rx_data;
    int         n_tests = 0, n_fail = 0, tx_req_n = 0, oe_cycles = 0, busy_cycles = 0;
    logic [7:0] rx_q[$], tx_src[$], pl[$];
    assign sda_line = sda_m & ~sda_oe;
    i2c_target_ctrl dut (
        .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req), .tx_data(tx_data),
        .busy(busy), .rd_mode(rd_mode)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (tx_req) begin
            tx_req_n++;
            tx_data = (tx_src.size() != 0) ? tx_src.pop_front() : 8'h00;
        end
        if (sda_oe) oe_cycles++;
        if (busy) busy_cycles++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic wq;
        repeat (Q) @(negedge clk);
    endtask
    task automatic bus_start;
        if (!scl) begin
            sda_m = 1'b1; wq;
            scl = 1'b1; wq;
        end
        sda_m = 1'b0; wq;
        scl = 1'b0; wq;
    endtask
    task automatic bus_stop;
        sda_m = 1'b0; wq;
        scl = 1'b1; wq;
        sda_m = 1'b1; wq; wq;
    endtask
    task automatic clk_bit(input logic b, output logic got);
        sda_m = b; wq;
        scl = 1'b1; wq;
        got = sda_line; wq;
        scl = 1'b0; wq;
    endtask
    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic g;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], g);
        clk_bit(1'b1, g);
        ack = ~g;
    endtask
    task automatic recv_byte(input logic m_ack, output logic [7:0] d);
        logic g;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, g);
            d[i] = g;
        end
        clk_bit(~m_ack, g);
    endtask
    // Whole transfer: START, address, payload pl (write) or read of pl.size() bytes, STOP.
    task automatic txn(input logic [6:0] addr, input logic rw);
        logic       hit, ack;
        logic [7:0] d;
        int         rx0, tr0, oe0, bz0;
        hit = (addr == TGT);
        rx0 = rx_q.size(); tr0 = tx_req_n; oe0 = oe_cycles; bz0 = busy_cycles;
        if (hit && rw) foreach (pl[i]) tx_src.push_back(pl[i]);
        bus_start;
        send_byte({addr, rw}, ack);
        check("addr_ack", ack, hit);
        check("busy_after_addr", busy, hit);
        if (hit) check("rd_mode", rd_mode, rw);
        if (!rw) begin
            foreach (pl[i]) begin
                send_byte(pl[i], ack);
                check("wr_ack", ack, hit);
            end
        end else if (hit) begin
            foreach (pl[i]) begin
                recv_byte(i != pl.size() - 1, d);
                check("rd_byte", d, pl[i]);
            end
            check("oe_after_nack", sda_oe, 0);
        end
        bus_stop;
        check("busy_after_stop", busy, 0);
        check("oe_after_stop", sda_oe, 0);
        check("rx_count", rx_q.size() - rx0, (hit && !rw) ? pl.size() : 0);
        if (hit && !rw) foreach (pl[i]) check("rx_data", rx_q[rx0 + i], pl[i]);
        check("tx_req_count", tx_req_n - tr0, (hit && rw) ? pl.size() : 0);
        if (!hit) begin
            check("oe_idle_frame", oe_cycles - oe0, 0);
            check("busy_idle_frame", busy_cycles - bz0, 0);
        end
    endtask
    initial begin
        logic       ack, g;
        logic [7:0] d;
        int         rx0, oe0, tr0;
        repeat (3) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_mode", rd_mode, 0);
        rst = 1'b0;
        wq;
        pl = '{8'hBB, 8'h5A};
        txn(TGT, 1'b0);
        pl = '{8'h11, 8'h22};
        txn(7'h0A, 1'b0);
        pl = '{8'hBB, 8'h3C};
        txn(TGT, 1'b1);
        // repeated START part-way through a write byte
        rx0 = rx_q.size();
        tx_src.push_back(8'h5A);
        bus_start;
        send_byte({TGT, 1'b0}, ack);
        check("rs_wr_ack", ack, 1);
        clk_bit(1'b1, g); clk_bit(1'b0, g); clk_bit(1'b1, g);
        bus_start;
        send_byte({TGT, 1'b1}, ack);
        check("rs_rd_ack", ack, 1);
        check("rs_rd_mode", rd_mode, 1);
        recv_byte(1'b0, d);
        check("rs_rd_byte", d, 8'h5A);
        bus_stop;
        check("rs_no_rx", rx_q.size() - rx0, 0);
        // reset while driving the address ACK
        bus_start;
        for (int i = 7; i >= 0; i--) clk_bit(((({TGT, 1'b0}) >> i) & 8'h01) != 0, g);
        sda_m = 1'b1;
        check("ack_driven", sda_oe, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst_oe", sda_oe, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk) rst = 1'b0;
        oe0 = oe_cycles;
        clk_bit(1'b1, g);
        check("post_rst_9th", g, 1);
        send_byte({TGT, 1'b0}, ack);
        check("post_rst_no_ack", ack, 0);
        check("post_rst_oe", oe_cycles - oe0, 0);
        bus_stop;
        // STOP in the middle of a read byte
        tr0 = tx_req_n;
        tx_src.push_back(8'hFF);
        bus_start;
        send_byte({TGT, 1'b1}, ack);
        check("mid_rd_ack", ack, 1);
        for (int i = 0; i < 3; i++) begin
            clk_bit(1'b1, g);
            check("mid_rd_bit", g, 1);
        end
        sda_m = 1'b0; wq;
        scl = 1'b1; wq;
        sda_m = 1'b1;
        repeat (2) @(negedge clk);
        check("stop_lat_busy_hold", busy, 1);
        @(negedge clk);
        check("stop_lat_busy", busy, 0);
        check("stop_lat_oe", sda_oe, 0);
        wq;
        scl = 1'b0; wq;
        oe0 = oe_cycles;
        send_byte({TGT, 1'b1}, ack);
        check("idle_no_ack", ack, 0);
        check("idle_no_oe", oe_cycles - oe0, 0);
        check("mid_rd_tx_req", tx_req_n - tr0, 1);
        bus_stop;
        // randomized transfers against the transaction model
        for (int t = 0; t < 8; t++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : TGT;
            pl.delete();
            for (int k = 0, n = $urandom_range(1, 3); k < n; k++) pl.push_back(8'($urandom));
            txn(a, 1'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
